// File: rtl/mig_serial_evaluator.sv
// Time-multiplexed majority-inverter-graph evaluator: one MAJ3 unit walks a programmed netlist, one node per cycle.
// Optional MIG_TRUTH_SWEEP_EN adds sweep/tt_out for a full 128-minterm truth-table sweep.
module mig_serial_evaluator #(
    parameter int MAX_NODES = 8,
    parameter int SEL_W     = 4,
    localparam int AW       = $clog2(MAX_NODES),
    localparam int IW       = 3 * (SEL_W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [AW:0]   num_nodes,
    input  logic          out_inv,
    input  logic [6:0]    x_in,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          result,
    output logic          err
`ifdef MIG_TRUTH_SWEEP_EN
    ,
    input  logic          sweep,
    output logic [127:0]  tt_out
`endif
);

    // Handshake: start is taken only in IDLE; busy is high for the whole EVAL phase and
    // done pulses for exactly one cycle (FIN) with result/err valid, which then hold until
    // the next accepted start.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]           state;
    logic [IW-1:0]        prog_mem [MAX_NODES];
    logic [MAX_NODES-1:0] nodes;
    logic [AW-1:0]        k;
    logic [AW:0]          num_cap;
    logic                 inv_cap;
    logic [6:0]           x_cap;
    logic                 fault_acc;

    logic [IW-1:0]        instr;
    logic [6:0]           x_cur;
    logic [7:0]           x_ext;
    logic [SEL_W-1:0]     sel_v;
    logic [SEL_W-1:0]     node_sel;
    logic                 bit_v;
    logic [2:0]           opv;
    logic                 op_fault;
    logic                 maj;
    logic                 node_val;
    logic                 fault_now;
    logic                 last_node;
    logic                 num_bad;
    logic                 sweep_more;

`ifdef MIG_TRUTH_SWEEP_EN
    logic                 sweep_cap;
    logic [6:0]           minterm;

    assign x_cur      = sweep_cap ? minterm : x_cap;
    assign sweep_more = sweep_cap && (minterm != 7'h7f);
`else
    assign x_cur      = x_cap;
    assign sweep_more = 1'b0;
`endif

    assign busy      = (state == S_EVAL);
    assign done      = (state == S_FIN);
    assign instr     = prog_mem[k];
    // Bit 0 stands in for const0 so that select codes 1..7 index x0..x6 directly.
    assign x_ext     = {x_cur, 1'b0};
    assign maj       = (opv[0] & opv[1]) | (opv[0] & opv[2]) | (opv[1] & opv[2]);
    assign node_val  = maj ^ inv_cap;
    assign fault_now = fault_acc | op_fault;
    assign last_node = ((AW+1)'(k) + (AW+1)'(1)) == num_cap;
    assign num_bad   = (num_nodes == '0) || (num_nodes > (AW+1)'(MAX_NODES));

    // Operand decode: a node operand is legal only if it refers to an already computed node.
    always_comb begin
        opv      = '0;
        op_fault = 1'b0;
        sel_v    = '0;
        node_sel = '0;
        bit_v    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel_v    = instr[i*(SEL_W+1) +: SEL_W];
            node_sel = sel_v - SEL_W'(8);
            bit_v    = 1'b0;
            if (int'(sel_v) < 8) begin
                bit_v = x_ext[sel_v[2:0]];
            end else if (int'(node_sel) >= int'(k) || int'(node_sel) >= MAX_NODES) begin
                op_fault = 1'b1;
            end else begin
                bit_v = nodes[node_sel[AW-1:0]];
            end
            opv[i] = bit_v ^ instr[i*(SEL_W+1) + SEL_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            num_cap   <= '0;
            inv_cap   <= 1'b0;
            x_cap     <= '0;
            fault_acc <= 1'b0;
            nodes     <= '0;
            result    <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < MAX_NODES; i++) begin
                prog_mem[i] <= '0;
            end
`ifdef MIG_TRUTH_SWEEP_EN
            sweep_cap <= 1'b0;
            minterm   <= '0;
            tt_out    <= '0;
`endif
        end else begin
            // Writes are blocked only while nodes are being evaluated; a write in the
            // start cycle lands before the first instruction fetch.
            if (prog_we && state != S_EVAL && int'(prog_addr) < MAX_NODES) begin
                prog_mem[prog_addr] <= prog_data;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_cap     <= x_in;
                        num_cap   <= num_nodes;
                        inv_cap   <= out_inv;
                        k         <= '0;
                        fault_acc <= 1'b0;
                        result    <= 1'b0;
`ifdef MIG_TRUTH_SWEEP_EN
                        sweep_cap <= sweep;
                        minterm   <= '0;
                        tt_out    <= '0;
`endif
                        if (num_bad) begin
                            err   <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            err   <= 1'b0;
                            state <= S_EVAL;
                        end
                    end
                end
                S_EVAL: begin
                    nodes[k] <= maj;
                    if (!last_node) begin
                        k         <= k + AW'(1);
                        fault_acc <= fault_now;
                    end else if (sweep_more) begin
                        k         <= '0;
                        fault_acc <= fault_now;
`ifdef MIG_TRUTH_SWEEP_EN
                        minterm         <= minterm + 7'd1;
                        tt_out[minterm] <= node_val;
`endif
                    end else begin
                        state  <= S_FIN;
                        result <= fault_now ? 1'b0 : node_val;
                        err    <= fault_now;
`ifdef MIG_TRUTH_SWEEP_EN
                        if (fault_now) begin
                            tt_out <= '0;
                        end else if (sweep_cap) begin
                            tt_out[minterm] <= node_val;
                        end
`endif
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mig_serial_evaluator.sv
// Directed self-checking bench for mig_serial_evaluator; define MIG_TRUTH_SWEEP_EN to include the sweep scenario.
module tb_mig_serial_evaluator;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [14:0] prog_data;
    logic [3:0]  num_nodes;
    logic        out_inv;
    logic [6:0]  x_in;
    logic        start;
    logic        busy;
    logic        done;
    logic        result;
    logic        err;
`ifdef MIG_TRUTH_SWEEP_EN
    logic         sweep;
    logic [127:0] tt_out;
`endif

    int n_pass;
    int n_total;

    mig_serial_evaluator dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .num_nodes (num_nodes),
        .out_inv   (out_inv),
        .x_in      (x_in),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err)
`ifdef MIG_TRUTH_SWEEP_EN
        ,
        .sweep     (sweep),
        .tt_out    (tt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ins(input logic ia, input logic [3:0] sa,
                                        input logic ib, input logic [3:0] sb,
                                        input logic ic, input logic [3:0] sc);
        return {ia, sa, ib, sb, ic, sc};
    endfunction

    task automatic prog(input logic [2:0] addr, input logic [14:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk); #1;
        prog_we   = 1'b0;
    endtask

    // Starts one evaluation; lat counts cycles from the start cycle to the done cycle.
    task automatic run(input logic [3:0] num, input logic inv, input logic [6:0] x,
                       output int lat, output logic res, output logic e, output logic busy1);
        num_nodes = num;
        out_inv   = inv;
        x_in      = x;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        busy1 = busy;
        while (!done && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        e   = err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int lat; logic res, e, b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0)   $display("FAIL reset_busy got %0b expected 0", busy);     else n_pass++;
        n_total++; if (done !== 1'b0)   $display("FAIL reset_done got %0b expected 0", done);     else n_pass++;
        n_total++; if (result !== 1'b0) $display("FAIL reset_result got %0b expected 0", result); else n_pass++;
        n_total++; if (err !== 1'b0)    $display("FAIL reset_err got %0b expected 0", err);       else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        // Cleared program: every operand is const0, so node value is 0 regardless of x.
        run(4'd1, 1'b0, 7'h7f, lat, res, e, b1);
        n_total++; if (res !== 1'b0) $display("FAIL reset_prog0 got %0b expected 0", res); else n_pass++;
        run(4'd1, 1'b1, 7'h7f, lat, res, e, b1);
        n_total++; if (res !== 1'b1) $display("FAIL reset_prog0_inv got %0b expected 1", res); else n_pass++;
    endtask

    task automatic test_basic();
        int lat; logic res, e, b1;
        prog(3'd0, ins(0, 4'd1, 0, 4'd2, 0, 4'd3));
        run(4'd1, 1'b0, 7'b0000011, lat, res, e, b1);
        n_total++; if (lat !== 2)    $display("FAIL basic_latency got %0d expected 2", lat); else n_pass++;
        n_total++; if (b1 !== 1'b1)  $display("FAIL basic_busy got %0b expected 1", b1);     else n_pass++;
        n_total++; if (res !== 1'b1) $display("FAIL basic_result got %0b expected 1", res);  else n_pass++;
        n_total++; if (e !== 1'b0)   $display("FAIL basic_err got %0b expected 0", e);       else n_pass++;
        run(4'd1, 1'b0, 7'b0000100, lat, res, e, b1);
        n_total++; if (res !== 1'b0) $display("FAIL basic_result_low got %0b expected 0", res); else n_pass++;
    endtask

    task automatic test_and_inv();
        int lat; logic res, e, b1;
        prog(3'd0, ins(0, 4'd0, 0, 4'd1, 0, 4'd2));
        run(4'd1, 1'b1, 7'b0000011, lat, res, e, b1);
        n_total++; if (res !== 1'b0) $display("FAIL and_inv_11 got %0b expected 0", res); else n_pass++;
        run(4'd1, 1'b1, 7'b0000001, lat, res, e, b1);
        n_total++; if (res !== 1'b1) $display("FAIL and_inv_01 got %0b expected 1", res); else n_pass++;
        // Inverted operand: MAJ(~0, x0, x1) is OR.
        prog(3'd0, ins(1, 4'd0, 0, 4'd1, 0, 4'd2));
        run(4'd1, 1'b0, 7'b0000010, lat, res, e, b1);
        n_total++; if (res !== 1'b1) $display("FAIL or_inv_10 got %0b expected 1", res); else n_pass++;
    endtask

    task automatic test_chain();
        int lat; logic res, e, b1;
        prog(3'd0, ins(0, 4'd1, 0, 4'd3, 0, 4'd6));
        prog(3'd1, ins(0, 4'd1, 0, 4'd4, 0, 4'd5));
        prog(3'd2, ins(0, 4'd8, 0, 4'd9, 0, 4'd7));
        run(4'd3, 1'b0, 7'b1011001, lat, res, e, b1);
        n_total++; if (lat !== 4)    $display("FAIL chain_latency got %0d expected 4", lat); else n_pass++;
        n_total++; if (res !== 1'b1) $display("FAIL chain_result got %0b expected 1", res);  else n_pass++;
        n_total++; if (e !== 1'b0)   $display("FAIL chain_err got %0b expected 0", e);       else n_pass++;
        run(4'd3, 1'b0, 7'b0000001, lat, res, e, b1);
        n_total++; if (res !== 1'b0) $display("FAIL chain_result_low got %0b expected 0", res); else n_pass++;
    endtask

    task automatic test_fault();
        int lat; logic res, e, b1;
        prog(3'd0, ins(0, 4'd9, 0, 4'd1, 0, 4'd2));
        run(4'd1, 1'b0, 7'h7f, lat, res, e, b1);
        n_total++; if (lat !== 2)    $display("FAIL fwd_latency got %0d expected 2", lat); else n_pass++;
        n_total++; if (e !== 1'b1)   $display("FAIL fwd_err got %0b expected 1", e);       else n_pass++;
        n_total++; if (res !== 1'b0) $display("FAIL fwd_result got %0b expected 0", res);  else n_pass++;
        prog(3'd0, ins(0, 4'd1, 0, 4'd8, 0, 4'd2));
        run(4'd1, 1'b1, 7'h7f, lat, res, e, b1);
        n_total++; if (e !== 1'b1)   $display("FAIL self_err got %0b expected 1", e);      else n_pass++;
        n_total++; if (res !== 1'b0) $display("FAIL self_result got %0b expected 0", res); else n_pass++;
        run(4'd0, 1'b1, 7'h7f, lat, res, e, b1);
        n_total++; if (lat !== 1)    $display("FAIL num0_latency got %0d expected 1", lat); else n_pass++;
        n_total++; if (e !== 1'b1)   $display("FAIL num0_err got %0b expected 1", e);       else n_pass++;
        n_total++; if (res !== 1'b0) $display("FAIL num0_result got %0b expected 0", res);  else n_pass++;
        run(4'd9, 1'b0, 7'h7f, lat, res, e, b1);
        n_total++; if (lat !== 1)    $display("FAIL num9_latency got %0d expected 1", lat); else n_pass++;
        n_total++; if (e !== 1'b1)   $display("FAIL num9_err got %0b expected 1", e);       else n_pass++;
    endtask

    task automatic test_ignore_during_eval();
        int lat; logic res, e, b1;
        prog(3'd0, ins(0, 4'd1, 0, 4'd2, 0, 4'd3));
        num_nodes = 4'd1;
        out_inv   = 1'b0;
        x_in      = 7'b0000011;
        start     = 1'b1;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b1) $display("FAIL ign_busy got %0b expected 1", busy); else n_pass++;
        prog_we   = 1'b1;
        prog_addr = 3'd0;
        prog_data = 15'd0;
        x_in      = 7'b0000000;
        @(posedge clk); #1;
        prog_we = 1'b0;
        n_total++; if (done !== 1'b1)   $display("FAIL ign_done got %0b expected 1", done);     else n_pass++;
        n_total++; if (result !== 1'b1) $display("FAIL ign_result got %0b expected 1", result); else n_pass++;
        @(posedge clk); #1;
        start = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL ign_restart_busy got %0b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL ign_restart_done got %0b expected 0", done); else n_pass++;
        run(4'd1, 1'b0, 7'b0000011, lat, res, e, b1);
        n_total++; if (res !== 1'b1) $display("FAIL ign_prog_kept got %0b expected 1", res); else n_pass++;
        n_total++; if (lat !== 2)    $display("FAIL ign_latency got %0d expected 2", lat);   else n_pass++;
    endtask

    task automatic test_write_start();
        int lat; logic res, e, b1;
        // Same-cycle write of AND(x0,x1) and start: new instruction must be used.
        prog_we   = 1'b1;
        prog_addr = 3'd0;
        prog_data = ins(0, 4'd0, 0, 4'd1, 0, 4'd2);
        run(4'd1, 1'b0, 7'b0000101, lat, res, e, b1);
        n_total++; if (res !== 1'b0) $display("FAIL wr_start_result got %0b expected 0", res); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat; logic res, e, b1;
        prog(3'd0, ins(0, 4'd1, 0, 4'd2, 0, 4'd3));
        run(4'd1, 1'b0, 7'b0000011, lat, res, e, b1);
        n_total++; if (res !== 1'b1) $display("FAIL b2b_first got %0b expected 1", res); else n_pass++;
        run(4'd1, 1'b0, 7'b0000100, lat, res, e, b1);
        n_total++; if (res !== 1'b0) $display("FAIL b2b_second got %0b expected 0", res); else n_pass++;
        run(4'd1, 1'b0, 7'b0000110, lat, res, e, b1);
        n_total++; if (res !== 1'b1) $display("FAIL b2b_third got %0b expected 1", res); else n_pass++;
        n_total++; if (lat !== 2)    $display("FAIL b2b_latency got %0d expected 2", lat); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat; logic res, e, b1;
        bit seen;
        prog(3'd0, ins(0, 4'd1, 0, 4'd3, 0, 4'd6));
        prog(3'd1, ins(0, 4'd1, 0, 4'd4, 0, 4'd5));
        prog(3'd2, ins(0, 4'd8, 0, 4'd9, 0, 4'd7));
        num_nodes = 4'd3;
        out_inv   = 1'b0;
        x_in      = 7'b1011001;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %0b expected 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rstmid_done got %0b expected 0", done); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL rstmid_no_done got %0b expected 0", seen); else n_pass++;
        run(4'd1, 1'b0, 7'h7f, lat, res, e, b1);
        n_total++; if (res !== 1'b0) $display("FAIL rstmid_zero_prog got %0b expected 0", res); else n_pass++;
        run(4'd3, 1'b1, 7'h7f, lat, res, e, b1);
        n_total++; if (res !== 1'b1) $display("FAIL rstmid_zero_chain got %0b expected 1", res); else n_pass++;
        n_total++; if (lat !== 4)    $display("FAIL rstmid_latency got %0d expected 4", lat);   else n_pass++;
    endtask

`ifdef MIG_TRUTH_SWEEP_EN
    task automatic test_sweep();
        int lat; logic res, e, b1;
        logic [127:0] exp_tt;
        exp_tt = {16{8'hE8}};
        prog(3'd0, ins(0, 4'd1, 0, 4'd2, 0, 4'd3));
        sweep = 1'b1;
        run(4'd1, 1'b0, 7'b0000000, lat, res, e, b1);
        sweep = 1'b0;
        n_total++; if (lat !== 129)     $display("FAIL sweep_latency got %0d expected 129", lat); else n_pass++;
        n_total++; if (tt_out !== exp_tt) $display("FAIL sweep_tt got %h expected %h", tt_out, exp_tt); else n_pass++;
        n_total++; if (res !== 1'b1)    $display("FAIL sweep_result got %0b expected 1", res);    else n_pass++;
        n_total++; if (e !== 1'b0)      $display("FAIL sweep_err got %0b expected 0", e);         else n_pass++;
    endtask
`endif

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        num_nodes = '0;
        out_inv   = 1'b0;
        x_in      = '0;
        start     = 1'b0;
`ifdef MIG_TRUTH_SWEEP_EN
        sweep     = 1'b0;
`endif
        test_reset();
        test_basic();
        test_and_inv();
        test_chain();
        test_fault();
        test_ignore_during_eval();
        test_write_start();
        test_back_to_back();
        test_reset_mid();
`ifdef MIG_TRUTH_SWEEP_EN
        test_sweep();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
